// File: rtl/axis_threshold_bank_if.sv
// AXI4-Stream beat bundle carrying threshold words into axis_threshold_bank.
interface axis_threshold_bank_if #(
  parameter int unsigned DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_threshold_bank.sv
// Captures one NUM_CH-word AXIS frame into a shadow bank and commits it atomically to thr_out.
// Optional feature: define THR_CLAMP_EN to clamp each captured word to THR_MAX.
module axis_threshold_bank #(
  parameter int unsigned       NUM_CH   = 4,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       THR_W    = 16,
  parameter logic [THR_W-1:0]  THR_INIT = '0,
  parameter logic [THR_W-1:0]  THR_MAX  = THR_W'(16'h7FFF)
) (
  input  logic                      clk,
  input  logic                      rst,
  axis_threshold_bank_if.slave      s_axis,
  output logic [NUM_CH*THR_W-1:0]   thr_out,
  output logic                      thr_update,
  output logic                      frame_err,
  output logic [7:0]                commit_cnt
);

  localparam int unsigned CNT_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          count;
  logic [NUM_CH*THR_W-1:0]   shadow;
  logic                      tready_q;
  logic                      commit_pend;
  logic                      beat_c;
  logic [THR_W-1:0]          word_c;
  logic                      unused_ok_c;

  assign s_axis.tready = tready_q;
  assign beat_c        = s_axis.tvalid && tready_q;
  assign unused_ok_c   = ^{s_axis.tdata, THR_MAX};

  // Incoming word as stored in the shadow bank
`ifdef THR_CLAMP_EN
  assign word_c = (s_axis.tdata[THR_W-1:0] > THR_MAX) ? THR_MAX : s_axis.tdata[THR_W-1:0];
`else
  assign word_c = s_axis.tdata[THR_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      shadow      <= '0;
      tready_q    <= 1'b1;
      commit_pend <= 1'b0;
      thr_out     <= {NUM_CH{THR_INIT}};
      thr_update  <= 1'b0;
      frame_err   <= 1'b0;
      commit_cnt  <= 8'd0;
    end else begin
      thr_update  <= 1'b0;
      frame_err   <= 1'b0;
      tready_q    <= 1'b1;
      commit_pend <= 1'b0;

      // Publish one cycle after COMMIT so the whole bank lands on a single edge
      if (commit_pend) begin
        thr_out    <= shadow;
        thr_update <= 1'b1;
        commit_cnt <= commit_cnt + 8'd1;
      end

      unique case (state)
        IDLE: begin
          if (beat_c) begin
            shadow[0 +: THR_W] <= word_c;
            if (s_axis.tlast) begin
              frame_err <= 1'b1;
            end else begin
              state <= LOAD;
              count <= CNT_W'(1);
            end
          end
        end
        LOAD: begin
          if (beat_c) begin
            for (int k = 1; k < int'(NUM_CH); k++) begin
              if (count == CNT_W'(k)) shadow[k*THR_W +: THR_W] <= word_c;
            end
            if (s_axis.tlast) begin
              count <= '0;
              if (count == LAST_IDX) begin
                state    <= COMMIT;
                tready_q <= 1'b0;
              end else begin
                state     <= IDLE;
                frame_err <= 1'b1;
              end
            end else if (count == LAST_IDX) begin
              state <= DRAIN;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (beat_c && s_axis.tlast) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end
        end
        COMMIT: begin
          state       <= IDLE;
          commit_pend <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
